// File: rtl/cm0_dap_dbg_pwrctl.sv
// Debug power-domain sequencer: brings the debug domain up and down in the order
// power -> reset release -> isolation release, and reverses it on power-down.

module cm0_dap_dbg_pwrctl_sync (
  input  logic clk,
  input  logic rst,
  input  logic se,
  input  logic d,
  output logic q
);
  logic meta;
  logic unused_se;

  // Scan enable is a hook for the library sync cell; the flops behave the same either way.
  assign unused_se = se;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module cm0_dap_dbg_pwrctl #(
  parameter int PRESENT = 1,
  parameter int RST_DLY = 3,
  parameter int ISO_DLY = 2
) (
  input  logic dbgclk,
  input  logic dbgreset,
  input  logic cdbgpwrupreq_i,
  input  logic dbgpwrok_i,
  input  logic SE,
  output logic cdbgpwrupack_o,
  output logic dbgpwren_o,
  output logic dbgiso_o,
  output logic dbgdomreset_o
);

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    PWRUP  = 3'd1,
    RSTREL = 3'd2,
    ISOREL = 3'd3,
    ON     = 3'd4,
    ISOSET = 3'd5,
    RSTSET = 3'd6,
    PWRDN  = 3'd7
  } state_t;

  localparam logic [3:0] RST_LOAD = 4'(RST_DLY);
  localparam logic [3:0] ISO_LOAD = 4'(ISO_DLY);

  generate
    if (PRESENT != 0) begin : g_ctl
      state_t     state, state_next;
      logic [3:0] count, count_next;
      logic       req_s, ok_s;
      logic       ack_next, pwren_next, iso_next, domreset_next;

      cm0_dap_dbg_pwrctl_sync u_req_sync (
        .clk (dbgclk),
        .rst (dbgreset),
        .se  (SE),
        .d   (cdbgpwrupreq_i),
        .q   (req_s)
      );

      cm0_dap_dbg_pwrctl_sync u_ok_sync (
        .clk (dbgclk),
        .rst (dbgreset),
        .se  (SE),
        .d   (dbgpwrok_i),
        .q   (ok_s)
      );

      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      always_comb begin
        state_next = state;
        count_next = (count != 4'd0) ? count - 4'd1 : count;

        case (state)
          OFF:     if (req_s) state_next = PWRUP;
          PWRUP:   if (ok_s) state_next = RSTREL;
                   else if (!req_s) state_next = PWRDN;
          RSTREL:  if (!req_s) state_next = PWRDN;
                   else if (count == 4'd0) state_next = ISOREL;
          ISOREL:  if (!req_s) state_next = RSTSET;
                   else if (count == 4'd0) state_next = ON;
          ON:      if (!req_s) state_next = ISOSET;
          ISOSET:  if (count == 4'd0) state_next = RSTSET;
          RSTSET:  if (count == 4'd0) state_next = PWRDN;
          PWRDN:   if (!ok_s) state_next = OFF;
          default: state_next = OFF;
        endcase

        // The counter is reloaded on every state change so each timed state starts fresh.
        if (state_next != state) begin
          case (state_next)
            RSTREL, RSTSET: count_next = RST_LOAD;
            ISOREL, ISOSET: count_next = ISO_LOAD;
            default:        count_next = 4'd0;
          endcase
        end

        // Outputs are decoded from the state being entered so they change on that same edge.
        pwren_next    = !(state_next inside {OFF, PWRDN});
        domreset_next = !(state_next inside {ISOREL, ON, ISOSET});
        iso_next      = (state_next != ON);
        ack_next      = cdbgpwrupack_o;
        if (state_next == ON)       ack_next = 1'b1;
        else if (state_next == OFF) ack_next = 1'b0;
      end

      always_ff @(posedge dbgclk or posedge dbgreset) begin
        if (dbgreset) begin
          state          <= OFF;
          count          <= 4'd0;
          cdbgpwrupack_o <= 1'b0;
          dbgpwren_o     <= 1'b0;
          dbgiso_o       <= 1'b1;
          dbgdomreset_o  <= 1'b1;
        end else begin
          state          <= state_next;
          count          <= count_next;
          cdbgpwrupack_o <= ack_next;
          dbgpwren_o     <= pwren_next;
          dbgiso_o       <= iso_next;
          dbgdomreset_o  <= domreset_next;
        end
      end
    end else begin : g_absent
      logic unused_in;

      assign unused_in      = ^{dbgclk, dbgreset, cdbgpwrupreq_i, dbgpwrok_i, SE};
      assign cdbgpwrupack_o = 1'b0;
      assign dbgpwren_o     = 1'b0;
      assign dbgiso_o       = 1'b1;
      assign dbgdomreset_o  = 1'b1;
    end
  endgenerate

endmodule
